// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT word registers.
// Supports one-shot and auto-reload modes and drives a level interrupt request.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:2]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        flag_q, flag_d;

    logic ctrlEn;
    logic autoReload;

    assign ctrlEn     = ctrl_q[0];
    assign autoReload = (ctrl_q[2:1] == 2'b01);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    // Timer FSM first, then bus writes override so a CTRL write wins over INT.
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        case (state_q)
            S_IDLE: begin
                if (ctrlEn) state_d = S_LOAD;
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!ctrlEn) begin
                    state_d = S_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = 32'd0;
                    flag_d  = 1'b1;
                    state_d = S_INT;
                end
            end
            S_INT: begin
                if (autoReload) begin
                    flag_d = 1'b0;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (we) begin
            case (addr)
                2'd0: begin
                    ctrl_d = din[3:0];
                    flag_d = 1'b0;
                end
                2'd1:    preset_d = din;
                default: ;
            endcase
        end
    end

    always_comb begin
        dout = 32'd0;
        case (addr)
            2'd0:    dout = {28'd0, ctrl_q};
            2'd1:    dout = preset_q;
            2'd2:    dout = count_q;
            default: dout = 32'd0;
        endcase
    end

    assign irq = ctrl_q[3] & flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter: reset, one-shot, auto-reload,
// disable mid-count, masking, ignored writes and edge preset values.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [3:2]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int tests;
    int errors;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single-cycle bus write; returns 1ns after the committing edge.
    task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        din  = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we   = 1'b0;
    endtask

    task automatic readReg(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = dout;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1;
        tick(2);
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int a = 0; a < 4; a++) begin
            readReg(a[1:0], v);
            tests++;
            if (v !== 32'd0) begin
                errors++;
                $display("[TB] FAIL reset_dout addr=%0d: got %h expected %h", a, v, 32'd0);
            end
        end
        tests++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_irq: got %b expected 0", irq);
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] v;
        busWrite(2'd1, 32'd5);
        busWrite(2'd0, 32'h9);
        tick(2);
        readReg(2'd2, v);
        tests++;
        if (v !== 32'd5) begin
            errors++;
            $display("[TB] FAIL oneshot_count_e2: got %0d expected 5", v);
        end
        tick(5);
        readReg(2'd2, v);
        tests++;
        if (v !== 32'd0 || irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL oneshot_e7: count=%0d irq=%b expected count=0 irq=1", v, irq);
        end
        tick(1);
        readReg(2'd0, v);
        tests++;
        if (v !== 32'h8) begin
            errors++;
            $display("[TB] FAIL oneshot_ctrl_e8: got %h expected 8", v);
        end
        tick(3);
        tests++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL oneshot_irq_hold: got %b expected 1", irq);
        end
        busWrite(2'd0, 32'h8);
        tests++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL oneshot_irq_clear: got %b expected 0", irq);
        end
    endtask

    task automatic test_auto_reload();
        logic [31:0] v;
        logic        expIrq;
        busWrite(2'd1, 32'd3);
        busWrite(2'd0, 32'hB);
        for (int k = 1; k <= 17; k++) begin
            tick(1);
            expIrq = ((k % 6) == 5);
            tests++;
            if (irq !== expIrq) begin
                errors++;
                $display("[TB] FAIL reload_irq_e%0d: got %b expected %b", k, irq, expIrq);
            end
            if ((k % 6) == 2) begin
                readReg(2'd2, v);
                tests++;
                if (v !== 32'd3) begin
                    errors++;
                    $display("[TB] FAIL reload_count_e%0d: got %0d expected 3", k, v);
                end
            end
        end
        busWrite(2'd0, 32'h0);
        tick(2);
    endtask

    task automatic test_disable_mid_count();
        logic [31:0] v;
        busWrite(2'd1, 32'd100);
        busWrite(2'd0, 32'h9);
        tick(52);
        readReg(2'd2, v);
        tests++;
        if (v !== 32'd50) begin
            errors++;
            $display("[TB] FAIL disable_count_e52: got %0d expected 50", v);
        end
        busWrite(2'd0, 32'h8);
        tick(5);
        readReg(2'd2, v);
        tests++;
        if (v !== 32'd49 || irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL disable_frozen: count=%0d irq=%b expected count=49 irq=0", v, irq);
        end
        busWrite(2'd0, 32'h9);
        tick(2);
        readReg(2'd2, v);
        tests++;
        if (v !== 32'd100) begin
            errors++;
            $display("[TB] FAIL disable_reload: got %0d expected 100", v);
        end
        busWrite(2'd0, 32'h0);
        tick(2);
    endtask

    task automatic test_mask_and_ignored();
        logic [31:0] v;
        busWrite(2'd1, 32'd2);
        busWrite(2'd0, 32'h1);
        tick(4);
        readReg(2'd2, v);
        tests++;
        if (v !== 32'd0 || irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mask_e4: count=%0d irq=%b expected count=0 irq=0", v, irq);
        end
        tick(1);
        readReg(2'd0, v);
        tests++;
        if (v !== 32'h0) begin
            errors++;
            $display("[TB] FAIL mask_ctrl_en_clear: got %h expected 0", v);
        end
        busWrite(2'd0, 32'h8);
        tick(1);
        tests++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mask_flag_cleared: got %b expected 0", irq);
        end
        busWrite(2'd2, 32'hDEAD);
        readReg(2'd2, v);
        tests++;
        if (v !== 32'd0) begin
            errors++;
            $display("[TB] FAIL ignored_count_write: got %h expected 0", v);
        end
        busWrite(2'd3, 32'h1234);
        readReg(2'd3, v);
        tests++;
        if (v !== 32'd0) begin
            errors++;
            $display("[TB] FAIL ignored_addr3: got %h expected 0", v);
        end
    endtask

    task automatic test_edge_values();
        logic [31:0] v;
        logic [31:0] presets [2];
        presets[0] = 32'd0;
        presets[1] = 32'd1;
        for (int i = 0; i < 2; i++) begin
            busWrite(2'd1, presets[i]);
            busWrite(2'd0, 32'h9);
            tick(2);
            tests++;
            if (irq !== 1'b0) begin
                errors++;
                $display("[TB] FAIL edge_p%0d_e2: got irq=%b expected 0", presets[i], irq);
            end
            tick(1);
            tests++;
            if (irq !== 1'b1) begin
                errors++;
                $display("[TB] FAIL edge_p%0d_e3: got irq=%b expected 1", presets[i], irq);
            end
            busWrite(2'd0, 32'h8);
            tests++;
            if (irq !== 1'b0) begin
                errors++;
                $display("[TB] FAIL edge_p%0d_clear: got irq=%b expected 0", presets[i], irq);
            end
            tick(1);
        end

        busWrite(2'd1, 32'hFFFF_FFFF);
        busWrite(2'd0, 32'h1);
        tick(2);
        readReg(2'd2, v);
        tests++;
        if (v !== 32'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL edge_max_load: got %h expected ffffffff", v);
        end
        tick(1);
        readReg(2'd2, v);
        tests++;
        if (v !== 32'hFFFF_FFFE) begin
            errors++;
            $display("[TB] FAIL edge_max_dec: got %h expected fffffffe", v);
        end

        @(negedge clk);
        reset = 1'b1;
        tick(1);
        for (int a = 0; a < 4; a++) begin
            readReg(a[1:0], v);
            tests++;
            if (v !== 32'd0) begin
                errors++;
                $display("[TB] FAIL midreset_dout addr=%0d: got %h expected 0", a, v);
            end
        end
        tests++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_irq: got %b expected 0", irq);
        end
        @(negedge clk);
        reset = 1'b0;
        tick(3);
        readReg(2'd2, v);
        tests++;
        if (v !== 32'd0) begin
            errors++;
            $display("[TB] FAIL postreset_idle_count: got %h expected 0", v);
        end
    endtask

    initial begin
        tests  = 0;
        errors = 0;
        reset  = 1'b1;
        addr   = 2'd0;
        we     = 1'b0;
        din    = 32'd0;

        test_reset();
        test_one_shot();
        test_auto_reload();
        test_disable_mid_count();
        test_mask_and_ignored();
        test_edge_values();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
